// File: rtl/i2s_master_tx.sv
// I2S bus master transmitter: divides clk into BCK/LRCK and shifts out one stereo pair per frame.
// Optional build macro I2S_MASTER_TX_HOLD_LAST_EN repeats the last sent pair on underrun instead of silence.
module i2s_master_tx #(
    parameter int WORD_SIZE   = 32,
    parameter int SAMPLE_SIZE = 24,
    parameter int BCK_DIV     = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [SAMPLE_SIZE-1:0] in_l,
    input  logic [SAMPLE_SIZE-1:0] in_r,
    output logic                   o_bck,
    output logic                   o_lrck,
    output logic                   o_dout,
    output logic                   frame_start,
    output logic                   underrun
);

    localparam int FRAME_BITS = 2 * WORD_SIZE;
    localparam int PAD        = WORD_SIZE - SAMPLE_SIZE;
    localparam int CNT_W      = $clog2(FRAME_BITS);
    localparam int DIV_W      = (BCK_DIV > 1) ? $clog2(BCK_DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(BCK_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(FRAME_BITS - 1);
    localparam logic [CNT_W-1:0] CNT_RIGHT = CNT_W'(WORD_SIZE);

    logic [DIV_W-1:0]       div_cnt_q, div_cnt_d;
    logic                   bck_q, bck_d;
    logic                   lrck_q, lrck_d;
    logic                   dout_q, dout_d;
    logic                   frame_start_q, frame_start_d;
    logic                   underrun_q, underrun_d;
    logic [CNT_W-1:0]       bit_cnt_q, bit_cnt_d;
    logic                   hold_valid_q, hold_valid_d;
    logic [SAMPLE_SIZE-1:0] hold_l_q, hold_l_d;
    logic [SAMPLE_SIZE-1:0] hold_r_q, hold_r_d;
    logic [FRAME_BITS-1:0]  shift_q, shift_d;
`ifdef I2S_MASTER_TX_HOLD_LAST_EN
    logic [SAMPLE_SIZE-1:0] last_l_q, last_l_d;
    logic [SAMPLE_SIZE-1:0] last_r_q, last_r_d;
`endif

    logic div_wrap_s;
    logic fall_tick_s;
    logic frame_load_s;
    logic in_ready_s;
    logic transfer_s;
    logic [CNT_W-1:0] next_cnt_s;

    assign in_ready_s = ~hold_valid_q & ~rst;
    assign in_ready   = in_ready_s;

    // Next-state logic: divider, slot counter, frame load/shift and the holding register.
    always_comb begin
        div_wrap_s    = (div_cnt_q == DIV_LAST);
        fall_tick_s   = div_wrap_s & bck_q;
        frame_load_s  = fall_tick_s & (bit_cnt_q == CNT_LAST);
        transfer_s    = in_valid & in_ready_s;

        div_cnt_d     = div_cnt_q;
        bck_d         = bck_q;
        lrck_d        = lrck_q;
        dout_d        = dout_q;
        frame_start_d = 1'b0;
        underrun_d    = 1'b0;
        bit_cnt_d     = bit_cnt_q;
        hold_valid_d  = hold_valid_q;
        hold_l_d      = hold_l_q;
        hold_r_d      = hold_r_q;
        shift_d       = shift_q;
        next_cnt_s    = bit_cnt_q;
`ifdef I2S_MASTER_TX_HOLD_LAST_EN
        last_l_d      = last_l_q;
        last_r_d      = last_r_q;
`endif

        if (div_wrap_s) begin
            div_cnt_d = {DIV_W{1'b0}};
            bck_d     = ~bck_q;
        end else begin
            div_cnt_d = div_cnt_q + DIV_W'(1);
        end

        if (frame_load_s) begin
            next_cnt_s = {CNT_W{1'b0}};
        end else begin
            next_cnt_s = bit_cnt_q + CNT_W'(1);
        end

        // The bit leaving the MSB goes to the pin; at load time it is the old frame's trailing pad zero.
        if (fall_tick_s) begin
            bit_cnt_d = next_cnt_s;
            lrck_d    = (next_cnt_s >= CNT_RIGHT);
            dout_d    = shift_q[FRAME_BITS-1];
            if (frame_load_s) begin
                frame_start_d = 1'b1;
                if (hold_valid_q) begin
                    shift_d = {hold_l_q, {PAD{1'b0}}, hold_r_q, {PAD{1'b0}}};
`ifdef I2S_MASTER_TX_HOLD_LAST_EN
                    last_l_d = hold_l_q;
                    last_r_d = hold_r_q;
`endif
                end else begin
                    underrun_d = 1'b1;
`ifdef I2S_MASTER_TX_HOLD_LAST_EN
                    shift_d = {last_l_q, {PAD{1'b0}}, last_r_q, {PAD{1'b0}}};
`else
                    shift_d = {FRAME_BITS{1'b0}};
`endif
                end
            end else begin
                shift_d = {shift_q[FRAME_BITS-2:0], 1'b0};
            end
        end else begin
            shift_d = shift_q;
        end

        // A transfer only happens with the holder empty, so it never collides with a full-holder load.
        if (transfer_s) begin
            hold_valid_d = 1'b1;
            hold_l_d     = in_l;
            hold_r_d     = in_r;
        end else if (frame_load_s) begin
            hold_valid_d = 1'b0;
        end else begin
            hold_valid_d = hold_valid_q;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt_q     <= {DIV_W{1'b0}};
            bck_q         <= 1'b0;
            lrck_q        <= 1'b0;
            dout_q        <= 1'b0;
            frame_start_q <= 1'b0;
            underrun_q    <= 1'b0;
            bit_cnt_q     <= CNT_LAST;
            hold_valid_q  <= 1'b0;
            hold_l_q      <= {SAMPLE_SIZE{1'b0}};
            hold_r_q      <= {SAMPLE_SIZE{1'b0}};
            shift_q       <= {FRAME_BITS{1'b0}};
`ifdef I2S_MASTER_TX_HOLD_LAST_EN
            last_l_q      <= {SAMPLE_SIZE{1'b0}};
            last_r_q      <= {SAMPLE_SIZE{1'b0}};
`endif
        end else begin
            div_cnt_q     <= div_cnt_d;
            bck_q         <= bck_d;
            lrck_q        <= lrck_d;
            dout_q        <= dout_d;
            frame_start_q <= frame_start_d;
            underrun_q    <= underrun_d;
            bit_cnt_q     <= bit_cnt_d;
            hold_valid_q  <= hold_valid_d;
            hold_l_q      <= hold_l_d;
            hold_r_q      <= hold_r_d;
            shift_q       <= shift_d;
`ifdef I2S_MASTER_TX_HOLD_LAST_EN
            last_l_q      <= last_l_d;
            last_r_q      <= last_r_d;
`endif
        end
    end

    assign o_bck       = bck_q;
    assign o_lrck      = lrck_q;
    assign o_dout      = dout_q;
    assign frame_start = frame_start_q;
    assign underrun    = underrun_q;

endmodule

// File: tb/tb_i2s_master_tx.sv
// Directed bench for i2s_master_tx (WORD_SIZE=32, SAMPLE_SIZE=24, BCK_DIV=2).
// Expected frame contents follow I2S_MASTER_TX_HOLD_LAST_EN when it is defined for the build.
module tb_i2s_master_tx;

    localparam int W          = 32;
    localparam int S          = 24;
    localparam int DIV        = 2;
    localparam int SLOT_CLKS  = 2 * DIV;
    localparam int FRAME_CLKS = 2 * W * SLOT_CLKS;
`ifdef I2S_MASTER_TX_HOLD_LAST_EN
    localparam bit HOLD_LAST = 1'b1;
`else
    localparam bit HOLD_LAST = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic [S-1:0] in_l = '0;
    logic [S-1:0] in_r = '0;
    logic         in_ready, o_bck, o_lrck, o_dout, frame_start, underrun;

    i2s_master_tx #(.WORD_SIZE(W), .SAMPLE_SIZE(S), .BCK_DIV(DIV)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_l(in_l), .in_r(in_r), .o_bck(o_bck), .o_lrck(o_lrck), .o_dout(o_dout),
        .frame_start(frame_start), .underrun(underrun)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int pcount = 0;
    bit pending = 1'b0;

    // exp packs {bck, lrck, dout, frame_start, underrun, in_ready}
    typedef struct {
        logic       rst;
        logic       valid;
        int         adv;
        logic [5:0] exp;
    } vec_t;
    vec_t tbl[12];

    function automatic logic [S-1:0] src_l(input int p);
        return 24'h100000 + 24'(p);
    endfunction

    function automatic logic [S-1:0] src_r(input int p);
        return 24'hF00000 - 24'(p);
    endfunction

    function automatic logic [63:0] frame_of(input logic [S-1:0] l, input logic [S-1:0] r);
        return {l, 8'h00, r, 8'h00};
    endfunction

    function automatic logic [5:0] outs();
        return {o_bck, o_lrck, o_dout, frame_start, underrun, in_ready};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic run_table(input int n);
        for (int i = 0; i < n; i++) begin
            rst      = tbl[i].rst;
            in_valid = tbl[i].valid;
            tick(tbl[i].adv);
            check($sformatf("vec%0d", i), 64'(outs()), 64'(tbl[i].exp));
        end
    endtask

    // Starts on the negedge right after a frame load (slot 0); slot k is sampled at cycle k*SLOT_CLKS.
    task automatic capture(input int ncyc, input bit src_on, input bit raise_end,
                           input logic [S-1:0] ql, input logic [S-1:0] qr,
                           output logic [63:0] f, output int ur_in);
        bit lrck_bad;
        int slot;
        f        = '0;
        ur_in    = 0;
        lrck_bad = 1'b0;
        for (int c = 0; c < ncyc; c++) begin
            slot = c / SLOT_CLKS;
            if (c % SLOT_CLKS == 0) begin
                if (slot == 0) f[0] = o_dout;
                else           f[64 - slot] = o_dout;
                if (o_lrck !== (slot >= W)) lrck_bad = 1'b1;
            end
            if (c > 0 && underrun === 1'b1) ur_in++;
            if (src_on) begin
                if (pending) begin
                    pcount++;
                    in_l = src_l(pcount);
                    in_r = src_r(pcount);
                end
                pending = in_valid && in_ready;
            end
            if (raise_end && c == ncyc - 1) begin
                in_valid = 1'b1;
                in_l     = ql;
                in_r     = qr;
            end
            @(negedge clk);
        end
        check("lrck_pattern", 64'(lrck_bad), 64'(0));
    endtask

    logic [63:0] f;
    int          u;
    logic [S-1:0] a_l, a_r, q_l, q_r, z_l, z_r;

    initial begin
        tbl[0]  = '{1'b1, 1'b0, 1,   6'b000000};
        tbl[1]  = '{1'b0, 1'b0, 1,   6'b000001};
        tbl[2]  = '{1'b0, 1'b0, 1,   6'b100001};
        tbl[3]  = '{1'b0, 1'b0, 1,   6'b100001};
        tbl[4]  = '{1'b0, 1'b0, 1,   6'b000111};
        tbl[5]  = '{1'b0, 1'b0, 1,   6'b000001};
        tbl[6]  = '{1'b0, 1'b0, 1,   6'b100001};
        tbl[7]  = '{1'b0, 1'b0, 125, 6'b100001};
        tbl[8]  = '{1'b0, 1'b0, 1,   6'b010001};
        tbl[9]  = '{1'b0, 1'b0, 127, 6'b110001};
        tbl[10] = '{1'b0, 1'b0, 1,   6'b000111};
        tbl[11] = '{1'b0, 1'b0, 1,   6'b000001};
        a_l = 24'h800001; a_r = 24'h7FFFFE;
        q_l = 24'hA5C3E1; q_r = 24'h1E3C5A;
        z_l = 24'hFFFFFF; z_r = 24'hFFFFFF;

        // Idle timing after reset with no data offered
        tick(2);
        run_table(12);

        // One pair offered before the first fall tick
        rst = 1'b1;
        tick(1);
        rst = 1'b0; in_valid = 1'b1; in_l = a_l; in_r = a_r;
        tick(1);
        check("ready_after_xfer", 64'(in_ready), 64'(0));
        in_valid = 1'b0;
        tick(2);
        check("ready_while_held", 64'(in_ready), 64'(0));
        tick(1);
        check("frame1_start", 64'({frame_start, underrun, in_ready}), 64'(3'b101));
        capture(FRAME_CLKS, 1'b0, 1'b0, '0, '0, f, u);
        check("frame1_data", f, frame_of(a_l, a_r));
        check("frame2_start", 64'({frame_start, underrun}), 64'(2'b11));

        // Streaming source: one transfer per frame, consecutive pairs
        pcount = 1; pending = 1'b0;
        in_l = src_l(1); in_r = src_r(1); in_valid = 1'b1;
        capture(FRAME_CLKS, 1'b1, 1'b0, '0, '0, f, u);
        check("frame2_data", f, HOLD_LAST ? frame_of(a_l, a_r) : 64'h0);
        for (int k = 1; k <= 3; k++) begin
            check($sformatf("stream%0d_start", k), 64'({frame_start, underrun}), 64'(2'b10));
            if (k == 3) in_valid = 1'b0;
            capture(FRAME_CLKS, (k < 3), 1'b0, '0, '0, f, u);
            check($sformatf("stream%0d_data", k), f, frame_of(src_l(k), src_r(k)));
            check($sformatf("stream%0d_no_ur", k), 64'(u), 64'(0));
        end

        // Skipped pair, then a pair offered exactly on the next load edge
        check("skip_start", 64'({frame_start, underrun}), 64'(2'b11));
        capture(FRAME_CLKS, 1'b0, 1'b1, q_l, q_r, f, u);
        check("skip_data", f, HOLD_LAST ? frame_of(src_l(3), src_r(3)) : 64'h0);
        check("late_start", 64'({frame_start, underrun, in_ready}), 64'(3'b110));
        in_valid = 1'b0;
        capture(FRAME_CLKS, 1'b0, 1'b0, '0, '0, f, u);
        check("late_data", f, HOLD_LAST ? frame_of(src_l(3), src_r(3)) : 64'h0);
        check("late_next_start", 64'({frame_start, underrun}), 64'(2'b10));

        // Pair held, reset pulsed in the right slot, held pair discarded
        in_valid = 1'b1; in_l = z_l; in_r = z_r;
        capture(40 * SLOT_CLKS, 1'b0, 1'b0, '0, '0, f, u);
        check("late_pair_left", 64'(f[63:32]), 64'({q_l, 8'h00}));
        check("held_before_rst", 64'(in_ready), 64'(0));
        in_valid = 1'b0;
        run_table(5);
        capture(FRAME_CLKS, 1'b0, 1'b0, '0, '0, f, u);
        check("post_rst_data", f, 64'h0);
        check("post_rst_next", 64'({frame_start, underrun}), 64'(2'b11));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
